// File: rtl/key_pkg.sv
// Shared types and constants for the key click decoder.
package key_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   localparam logic [1:0] CLICK_SINGLE = 2'd1;
   localparam logic [1:0] CLICK_DOUBLE = 2'd2;
   localparam logic [1:0] CLICK_TRIPLE = 2'd3;

   localparam logic [3:0] LED_RESET = 4'b0001;

   // Grouping window length in clock cycles.
   function automatic int unsigned window_cyc(input int unsigned clk_freq_hz,
                                              input int unsigned window_ms);
      return (clk_freq_hz / 1000) * window_ms;
   endfunction

endpackage

// File: rtl/key_click_decoder_timer.sv
// Click window timer: counts cycles while a group is open, flags the last window cycle.
module click_window_timer #(
   parameter int unsigned WINDOW_CYC = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic run,
   output logic expire
);

   localparam int unsigned TW = $clog2(WINDOW_CYC);

   logic [TW-1:0] cnt_q;

   assign expire = run && (cnt_q == TW'(WINDOW_CYC - 1));

   // Cleared on expiry as well so the counter never wraps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clear || expire) begin
         cnt_q <= '0;
      end else if (run) begin
         cnt_q <= cnt_q + TW'(1);
      end
   end

endmodule

// File: rtl/key_click_decoder.sv
// Groups debounced key presses into single/double/triple click events.
// Optional LED pattern driver enabled by defining KEY_CLICK_LED_EN.
module key_click_decoder
   import key_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = 50_000_000,
   parameter int unsigned WINDOW_MS   = 300,
   parameter int unsigned MAX_CLICKS  = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_valid,
   output logic       click_evt,
   output logic [1:0] click_cnt,
   output logic       busy,
   output logic [3:0] led
);

   localparam int unsigned WINDOW_CYC = window_cyc(CLK_FREQ_HZ, WINDOW_MS);
   localparam logic [1:0]  MAX_C      = 2'(MAX_CLICKS);

   state_t     state_q, state_d;
   logic [1:0] count_q, count_d;
   logic [1:0] count_inc;
   logic       evt_q, evt_d;
   logic [1:0] cnt_q, cnt_d;
   logic       busy_q;
   logic       clear_c;
   logic       run_c;
   logic       expire_c;

   assign run_c = (state_q == ST_WAIT);

   click_window_timer #(
      .WINDOW_CYC (WINDOW_CYC)
   ) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (clear_c),
      .run    (run_c),
      .expire (expire_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         count_q <= 2'd0;
         evt_q   <= 1'b0;
         cnt_q   <= 2'd0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         evt_q   <= evt_d;
         cnt_q   <= cnt_d;
         busy_q  <= (state_d == ST_WAIT);
      end
   end

   // A press always wins over expiry; the timer restarts on every press.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      evt_d     = 1'b0;
      cnt_d     = cnt_q;
      clear_c   = 1'b0;
      count_inc = 2'(count_q + 2'd1);
      unique case (state_q)
         ST_IDLE: begin
            if (key_valid) begin
               clear_c = 1'b1;
               if (MAX_CLICKS == 1) begin
                  evt_d   = 1'b1;
                  cnt_d   = CLICK_SINGLE;
                  count_d = 2'd0;
               end else begin
                  count_d = CLICK_SINGLE;
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (key_valid) begin
               clear_c = 1'b1;
               if (count_inc == MAX_C) begin
                  state_d = ST_IDLE;
                  evt_d   = 1'b1;
                  cnt_d   = MAX_C;
                  count_d = 2'd0;
               end else begin
                  count_d = count_inc;
               end
            end else if (expire_c) begin
               state_d = ST_IDLE;
               evt_d   = 1'b1;
               cnt_d   = count_q;
               count_d = 2'd0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign click_evt = evt_q;
   assign click_cnt = cnt_q;
   assign busy      = busy_q;

`ifdef KEY_CLICK_LED_EN
   logic [3:0] led_q, led_d;

   // LED follows the event being registered this edge, so it changes with click_evt.
   always_comb begin
      led_d = led_q;
      if (evt_d) begin
         case (cnt_d)
            CLICK_SINGLE: led_d = {led_q[2:0], led_q[3]};
            CLICK_DOUBLE: led_d = ~led_q;
            CLICK_TRIPLE: led_d = LED_RESET;
            default:      led_d = led_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led_q <= LED_RESET;
      end else begin
         led_q <= led_d;
      end
   end

   assign led = led_q;
`else
   assign led = 4'b0000;
`endif

endmodule
